// File: rtl/acc_quant_buf.sv
// acc_quant_buf: per-column accumulation buffer behind the systolic array.
// Each column accumulates DEPTH rows of partial sums over a configurable
// number of passes (columns may be skewed in time), then every row is
// drained through a rounding, saturating quantizer under valid/ready.
// Optional feature: define ACC_RELU_EN to clamp negative accumulations to 0
// before quantization.
module acc_quant_buf #(
  parameter int PE_SIZE     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int PSUM_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int PASS_WIDTH  = 4,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic [PASS_WIDTH-1:0]            cfg_pass_num,
  input  logic [SHIFT_WIDTH-1:0]           cfg_shift,
  input  logic [PE_SIZE-1:0]               psum_en_i,
  input  logic [PSUM_WIDTH*PE_SIZE-1:0]    psum_row_i,
  input  logic                             out_ready_i,
  output logic                             out_valid_o,
  output logic [DATA_WIDTH*PE_SIZE-1:0]    psum_row_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(DEPTH - 1);
  localparam logic signed [PSUM_WIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic signed [PSUM_WIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
  localparam logic signed [PSUM_WIDTH-1:0] Q_MAX = PSUM_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PSUM_WIDTH-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                        state;
  logic [PASS_WIDTH-1:0]         pass_num;
  logic [SHIFT_WIDTH-1:0]        shift;
  logic [PTR_W-1:0]              rd_ptr;
  logic [PTR_W-1:0]              wr_ptr   [PE_SIZE];
  logic [PASS_WIDTH-1:0]         pass_cnt [PE_SIZE];
  logic signed [PSUM_WIDTH-1:0]  mem      [PE_SIZE][DEPTH];

  logic signed [PSUM_WIDTH-1:0]  psum_col [PE_SIZE];
  logic signed [PSUM_WIDTH-1:0]  acc_new  [PE_SIZE];
  logic [PE_SIZE-1:0]            col_done;
  logic [PE_SIZE-1:0]            col_wr;
  logic [PE_SIZE-1:0]            col_done_next;
  logic [PE_SIZE-1:0]            stray;

  function automatic logic signed [PSUM_WIDTH-1:0] sat_add(
    input logic signed [PSUM_WIDTH-1:0] a,
    input logic signed [PSUM_WIDTH-1:0] b
  );
    logic [PSUM_WIDTH:0] s;
    s = {a[PSUM_WIDTH-1], a} + {b[PSUM_WIDTH-1], b};
    if (s[PSUM_WIDTH] != s[PSUM_WIDTH-1])
      sat_add = s[PSUM_WIDTH] ? PSUM_MIN : PSUM_MAX;
    else
      sat_add = s[PSUM_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] quantize(
    input logic signed [PSUM_WIDTH-1:0] v_in,
    input logic [SHIFT_WIDTH-1:0]       sh
  );
    logic signed [PSUM_WIDTH-1:0] v;
    logic signed [PSUM_WIDTH-1:0] rnd;
    v = v_in;
`ifdef ACC_RELU_EN
    if (v < 0) v = '0;
`endif
    if (sh != '0) begin
      rnd = PSUM_WIDTH'(1) << (sh - SHIFT_WIDTH'(1));
      v = sat_add(v, rnd);
    end
    v = v >>> sh;
    if (v > Q_MAX)
      quantize = Q_MAX[DATA_WIDTH-1:0];
    else if (v < Q_MIN)
      quantize = Q_MIN[DATA_WIDTH-1:0];
    else
      quantize = v[DATA_WIDTH-1:0];
  endfunction

  // Per-column write qualification, read-modify-write value and completion look-ahead
  always_comb begin
    for (int c = 0; c < PE_SIZE; c++) begin
      psum_col[c]      = psum_row_i[(PE_SIZE-1-c)*PSUM_WIDTH +: PSUM_WIDTH];
      col_done[c]      = (pass_cnt[c] == pass_num);
      col_wr[c]        = (state == ACCUM) && psum_en_i[c] && !col_done[c];
      acc_new[c]       = sat_add((pass_cnt[c] == '0) ? '0 : mem[c][wr_ptr[c]], psum_col[c]);
      col_done_next[c] = col_done[c] ||
                         (col_wr[c] && (wr_ptr[c] == LAST_ROW) &&
                          (PASS_WIDTH'(pass_cnt[c] + 1'b1) == pass_num));
    end
    stray = psum_en_i & ~col_wr;
  end

  // Quantized view of the row under the read pointer, zero when nothing is offered
  always_comb begin
    psum_row_o = '0;
    if (out_valid_o) begin
      for (int c = 0; c < PE_SIZE; c++)
        psum_row_o[(PE_SIZE-1-c)*DATA_WIDTH +: DATA_WIDTH] = quantize(mem[c][rd_ptr], shift);
    end
  end

  // Accumulator storage; deliberately unreset since pass 0 ignores old contents
  always_ff @(posedge clk) begin
    for (int c = 0; c < PE_SIZE; c++)
      if (!rst && col_wr[c]) mem[c][wr_ptr[c]] <= acc_new[c];
  end

  // Tile sequencing: config latch, per-column pointers, drain handshake and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pass_num    <= '0;
      shift       <= '0;
      rd_ptr      <= '0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      for (int c = 0; c < PE_SIZE; c++) begin
        wr_ptr[c]   <= '0;
        pass_cnt[c] <= '0;
      end
    end else begin
      done_o <= 1'b0;
      if (|stray) err_o <= 1'b1;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            pass_num <= (cfg_pass_num == '0) ? PASS_WIDTH'(1) : cfg_pass_num;
            shift    <= cfg_shift;
            rd_ptr   <= '0;
            err_o    <= 1'b0;
            busy_o   <= 1'b1;
            state    <= ACCUM;
            for (int c = 0; c < PE_SIZE; c++) begin
              wr_ptr[c]   <= '0;
              pass_cnt[c] <= '0;
            end
          end
        end
        ACCUM: begin
          for (int c = 0; c < PE_SIZE; c++) begin
            if (col_wr[c]) begin
              if (wr_ptr[c] == LAST_ROW) begin
                wr_ptr[c]   <= '0;
                pass_cnt[c] <= pass_cnt[c] + 1'b1;
              end else begin
                wr_ptr[c] <= wr_ptr[c] + 1'b1;
              end
            end
          end
          if (&col_done_next) begin
            state       <= DRAIN;
            out_valid_o <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_valid_o && out_ready_i) begin
            if (rd_ptr == LAST_ROW) begin
              rd_ptr      <= '0;
              out_valid_o <= 1'b0;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
              state       <= IDLE;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_quant_buf.sv
// tb_acc_quant_buf: randomized and directed stimulus for acc_quant_buf with a
// behavioural reference model (write counts per column, integer arithmetic
// quantization) compared against the DUT on every cycle.
module tb_acc_quant_buf;

  localparam int PE    = 4;
  localparam int DW    = 8;
  localparam int PW    = 32;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_start = 1'b0;
  logic [3:0]         cfg_pass_num = '0;
  logic [4:0]         cfg_shift = '0;
  logic [PE-1:0]      psum_en_i = '0;
  logic [PW*PE-1:0]   psum_row_i = '0;
  logic               out_ready_i = 1'b0;
  logic               out_valid_o;
  logic [DW*PE-1:0]   psum_row_o;
  logic               busy_o;
  logic               done_o;
  logic               err_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  // Reference model state: phase 0 idle, 1 accumulating, 2 draining
  int     m_phase = 0;
  int     m_pass  = 1;
  int     m_shift = 0;
  int     m_row   = 0;
  bit     m_done  = 1'b0;
  bit     m_err   = 1'b0;
  longint acc [PE][DEPTH];
  int     writes [PE];
  int     mr;
  longint mbase;
  bit     mall;

  acc_quant_buf dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_pass_num (cfg_pass_num),
    .cfg_shift    (cfg_shift),
    .psum_en_i    (psum_en_i),
    .psum_row_i   (psum_row_i),
    .out_ready_i  (out_ready_i),
    .out_valid_o  (out_valid_o),
    .psum_row_o   (psum_row_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic logic [DW-1:0] qModel(input longint v, input int sh);
    longint t;
    t = v;
`ifdef ACC_RELU_EN
    if (t < 0) t = 0;
`endif
    if (sh > 0) t = sat32(t + (longint'(1) << (sh - 1)));
    t = t >>> sh;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t[DW-1:0];
  endfunction

  function automatic longint colVal(input int c);
    logic [PW-1:0] w;
    w = psum_row_i[(PE-1-c)*PW +: PW];
    return longint'($signed(w));
  endfunction

  function automatic logic [PW*PE-1:0] packSame(input int v);
    logic [PW*PE-1:0] r;
    for (int c = 0; c < PE; c++) r[c*PW +: PW] = v;
    return r;
  endfunction

  function automatic int randPsum();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 400) - 200;
      1: return $urandom_range(0, 200000) - 100000;
      2: return int'($urandom);
      default: return $urandom_range(0, 60) - 30;
    endcase
  endfunction

  function automatic logic [PW*PE-1:0] randRow();
    logic [PW*PE-1:0] r;
    for (int c = 0; c < PE; c++) r[c*PW +: PW] = randPsum();
    return r;
  endfunction

  // Reference model: advances on each rising edge from the bench-driven inputs only
  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_phase = 0;
      m_err   = 1'b0;
      m_row   = 0;
    end else begin
      case (m_phase)
        0: begin
          if (psum_en_i != '0) m_err = 1'b1;
          if (cfg_start) begin
            m_pass  = (cfg_pass_num == 0) ? 1 : int'(cfg_pass_num);
            m_shift = int'(cfg_shift);
            m_err   = 1'b0;
            m_row   = 0;
            m_phase = 1;
            for (int c = 0; c < PE; c++) writes[c] = 0;
          end
        end
        1: begin
          mall = 1'b1;
          for (int c = 0; c < PE; c++) begin
            if (psum_en_i[c]) begin
              if (writes[c] < m_pass * DEPTH) begin
                mr    = writes[c] % DEPTH;
                mbase = (writes[c] < DEPTH) ? 0 : acc[c][mr];
                acc[c][mr] = sat32(mbase + colVal(c));
                writes[c]++;
              end else begin
                m_err = 1'b1;
              end
            end
            if (writes[c] != m_pass * DEPTH) mall = 1'b0;
          end
          if (mall) m_phase = 2;
        end
        default: begin
          if (psum_en_i != '0) m_err = 1'b1;
          if (out_ready_i) begin
            m_row++;
            if (m_row == DEPTH) begin
              m_row   = 0;
              m_phase = 0;
              m_done  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Compare the DUT against the model on every falling edge
  always @(negedge clk) begin
    logic [3:0]       exp_ctrl;
    logic [3:0]       act_ctrl;
    logic [DW*PE-1:0] exp_row;
    if (checking) begin
      exp_ctrl = {m_phase != 0, m_phase == 2, m_done, m_err};
      act_ctrl = {busy_o, out_valid_o, done_o, err_o};
      n_tests++;
      if (act_ctrl !== exp_ctrl) begin
        n_fail++;
        $display("[TB] FAIL ctrl t=%0t busy/valid/done/err got %b want %b", $time, act_ctrl, exp_ctrl);
      end
      if (m_phase == 2) begin
        exp_row = '0;
        for (int c = 0; c < PE; c++)
          exp_row[(PE-1-c)*DW +: DW] = qModel(acc[c][m_row], m_shift);
        n_tests++;
        if (psum_row_o !== exp_row) begin
          n_fail++;
          $display("[TB] FAIL row t=%0t row %0d got %h want %h", $time, m_row, psum_row_o, exp_row);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s got %h want %h", name, actual, expected);
    end
  endtask

  task automatic startTile(input int pass, input int sh);
    cfg_start    = 1'b1;
    cfg_pass_num = 4'(pass);
    cfg_shift    = 5'(sh);
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [PE-1:0] en, input logic [PW*PE-1:0] row);
    psum_en_i  = en;
    psum_row_i = row;
    tick();
    psum_en_i = '0;
  endtask

  task automatic drainTile(input bit rnd_ready);
    int budget;
    budget = 0;
    while (m_phase == 2 && budget < 200) begin
      out_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      budget++;
    end
    out_ready_i = 1'b0;
    if (budget >= 200) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain_timeout phase %0d", m_phase);
    end else begin
      checkOutput("drain_done", 64'(done_o), 64'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int budget;
    // Reset state
    tick();
    checking = 1'b1;
    tick();
    checkOutput("reset_state", 64'({busy_o, out_valid_o, done_o, err_o, psum_row_o}), 64'd0);
    rst = 1'b0;

    // pass_num=1, shift=0, rows 1..4, ready high
    startTile(1, 0);
    for (int r = 0; r < DEPTH; r++) applyStimulus(4'hF, packSame(r + 1));
    checkOutput("t1_valid", 64'(out_valid_o), 64'd1);
    checkOutput("t1_row0", 64'(psum_row_o), 64'h01010101);
    out_ready_i = 1'b1;
    tick(); checkOutput("t1_row1", 64'(psum_row_o), 64'h02020202);
    tick(); checkOutput("t1_row2", 64'(psum_row_o), 64'h03030303);
    tick(); checkOutput("t1_row3", 64'(psum_row_o), 64'h04040404);
    tick(); checkOutput("t1_done", 64'({done_o, out_valid_o, busy_o}), 64'b100);
    out_ready_i = 1'b0;

    // Start accepted in the done cycle: pass_num=3, shift=2, psum=10 -> 8
    startTile(3, 2);
    checkOutput("t2_busy", 64'(busy_o), 64'd1);
    for (int k = 0; k < 3 * DEPTH; k++) applyStimulus(4'hF, packSame(10));
    checkOutput("t2_row0", 64'(psum_row_o), 64'h08080808);
    drainTile(1'b0);

    // Output saturation
    startTile(1, 0);
    for (int k = 0; k < DEPTH; k++) applyStimulus(4'hF, packSame(1000));
    checkOutput("sat_pos", 64'(psum_row_o), 64'h7f7f7f7f);
    drainTile(1'b0);
    startTile(1, 0);
    for (int k = 0; k < DEPTH; k++) applyStimulus(4'hF, packSame(-1000));
`ifdef ACC_RELU_EN
    checkOutput("sat_neg", 64'(psum_row_o), 64'h00000000);
`else
    checkOutput("sat_neg", 64'(psum_row_o), 64'h80808080);
`endif
    drainTile(1'b0);

    // Backpressure on row 1, plus a stray write during drain
    startTile(1, 0);
    for (int k = 0; k < DEPTH; k++) applyStimulus(4'hF, packSame(11 * (k + 1)));
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_hold", 64'(psum_row_o), 64'h16161616);
      if (k == 1) psum_en_i = 4'h2;
      tick();
      psum_en_i = '0;
    end
    checkOutput("bp_err", 64'(err_o), 64'd1);
    drainTile(1'b0);

    // Skewed columns, pass_num=2, extra write on finished column 0
    startTile(2, 0);
    for (int k = 0; k < 11; k++) begin
      logic [PE-1:0] en;
      for (int c = 0; c < PE; c++) en[c] = (k >= c) && (k < c + 2 * DEPTH);
      if (k == 8) en[0] = 1'b1;
      applyStimulus(en, randRow());
    end
    checkOutput("skew_valid", 64'({out_valid_o, err_o}), 64'b11);
    drainTile(1'b1);

    // Randomized tiles with random backpressure and ignored mid-tile starts
    for (int t = 0; t < 8; t++) begin
      startTile($urandom_range(0, 3), $urandom_range(0, 12));
      budget = 0;
      while (m_phase == 1 && budget < 300) begin
        cfg_start    = ($urandom_range(0, 7) == 0);
        cfg_pass_num = 4'($urandom);
        cfg_shift    = 5'($urandom);
        applyStimulus(4'($urandom_range(0, 15)), randRow());
        budget++;
      end
      cfg_start = 1'b0;
      if (m_phase != 2) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL accum_timeout phase %0d", m_phase);
      end
      drainTile(1'b1);
    end

    // Reset mid-accumulation discards the tile and clears error
    startTile(1, 0);
    for (int k = 0; k < DEPTH + 1; k++) applyStimulus(4'h1, packSame(7));
    checkOutput("pre_rst_err", 64'({busy_o, err_o}), 64'b11);
    rst = 1'b1;
    cfg_start = 1'b1;
    tick();
    rst = 1'b0;
    cfg_start = 1'b0;
    checkOutput("mid_rst", 64'({busy_o, out_valid_o, done_o, err_o}), 64'd0);
    startTile(1, 0);
    for (int k = 0; k < DEPTH; k++) applyStimulus(4'hF, packSame(5));
    checkOutput("post_rst_row", 64'(psum_row_o), 64'h05050505);
    drainTile(1'b0);

    tick();
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
